alu_cmd_sequencer: RTL and testbench

//  Upstream issue stage for the 4-bit combinational ALU. Buffers {opcode,a,b}

---
 rtl/alu_cmd_sequencer_pkg.sv | 27 ++
 rtl/alu_cmd_fifo.sv | 71 +++++++
 rtl/alu_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings,
// command field widths and small decode helpers.
package alu_cmd_sequencer_pkg;

    // Opcode field width and encodings understood by the downstream ALU.
    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD  = 3'b000;
    localparam logic [OPW-1:0] OP_SUB  = 3'b001;
    localparam logic [OPW-1:0] OP_MUL  = 3'b010;
    localparam logic [OPW-1:0] OP_DIV  = 3'b011;
    localparam logic [OPW-1:0] OP_MOD  = 3'b100;
    localparam logic [OPW-1:0] OP_XOR  = 3'b101;
    localparam logic [OPW-1:0] OP_NOT  = 3'b110;
    localparam logic [OPW-1:0] OP_LAND = 3'b111;

    // A stored command is {opcode, a, b, tag}; this gives its packed width.
    function automatic int cmd_width(input int dw, input int tagw);
        return OPW + 2 * dw + tagw;
    endfunction

    // Opcodes whose result is undefined when the divisor is zero.
    function automatic logic is_div_op(input logic [OPW-1:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with a combinational head-of-queue view. Push is ignored
// when full and pop is ignored when empty, so callers may drive them freely.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // The head must be visible in the same cycle it becomes valid, so the
    // storage is read asynchronously at the read pointer.
    assign head = mem_q[rd_ptr_q];

    // Occupancy update: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write; entries need no reset since occupancy tracks validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit combinational ALU: queues tagged commands, presents
// the oldest one to the ALU, and captures the result (or a divide-by-zero
// error) in a valid/ready output register.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 4,
    parameter int TAGW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_opcode,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_b,
    output logic [2:0]      alu_opcode,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    input  logic [DW-1:0]   alu_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_x,
    output logic [TAGW-1:0] out_tag,
    output logic            out_err,
    output logic            busy
);

    localparam int CW = cmd_width(DW, TAGW);

    logic [CW-1:0]   wr_data;
    logic [CW-1:0]   head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    logic [OPW-1:0]  head_op;
    logic [DW-1:0]   head_a;
    logic [DW-1:0]   head_b;
    logic [TAGW-1:0] head_tag;
    logic            zero_div;

    logic [TAGW-1:0] tag_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_x_q;
    logic [TAGW-1:0] out_tag_q;
    logic            out_err_q;

    // Acceptance depends only on occupancy; a full queue never accepts, even
    // when the head leaves in the same cycle.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    // The head moves into the output register whenever that register is free
    // or being drained this cycle.
    assign pop = !fifo_empty && (!out_valid_q || out_ready);

    assign wr_data = {in_opcode, in_a, in_b, tag_q};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    assign head_op  = head[CW-1 -: OPW];
    assign head_a   = head[2*DW+TAGW-1 -: DW];
    assign head_b   = head[DW+TAGW-1 -: DW];
    assign head_tag = head[TAGW-1:0];

    // ALU inputs idle at zero when nothing is queued so the ALU sees no stale data.
    assign alu_opcode = fifo_empty ? '0 : head_op;
    assign alu_a      = fifo_empty ? '0 : head_a;
    assign alu_b      = fifo_empty ? '0 : head_b;

    // The ALU result for a/0 is undefined, so it is replaced before capture.
    assign zero_div = is_div_op(head_op) && (head_b == '0);

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;
    assign busy      = !fifo_empty || out_valid_q;

    // Sequence tag assigned to each accepted command; wraps at 2^TAGW.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else if (push) begin
            tag_q <= tag_q + TAGW'(1);
        end
    end

    // Output register: load on pop, clear valid when drained with nothing
    // behind it, otherwise hold (including under back-pressure).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_tag_q   <= head_tag;
            if (zero_div) begin
                out_x_q   <= '1;
                out_err_q <= 1'b1;
            end else begin
                out_x_q   <= alu_x;
                out_err_q <= 1'b0;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural model of the ALU.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_opcode = 3'b000;
    logic [3:0] in_a = 4'h0;
    logic [3:0] in_b = 4'h0;
    logic [2:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_x;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_x;
    logic [3:0] out_tag;
    logic       out_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4), .DW(4), .TAGW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_x      (alu_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Stand-in for the 4-bit ALU; a/0 returns a junk value that must never escape.
    always_comb begin
        alu_x = 4'h0;
        case (alu_opcode)
            3'b000: alu_x = alu_a + alu_b;
            3'b001: alu_x = alu_a - alu_b;
            3'b010: alu_x = alu_a * alu_b;
            3'b011: alu_x = (alu_b == 4'h0) ? 4'h6 : alu_a / alu_b;
            3'b100: alu_x = (alu_b == 4'h0) ? 4'h6 : alu_a % alu_b;
            3'b101: alu_x = alu_a ^ alu_b;
            3'b110: alu_x = ~alu_a;
            default: alu_x = ((alu_a != 4'h0) && (alu_b != 4'h0)) ? 4'h1 : 4'h0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        in_valid  = v;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        set_cmd(1'b0, 3'b000, 4'h0, 4'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    // Directed stream vectors: opcode, a, b, expected x, expected err.
    task automatic get_vec(input int i, output logic [2:0] op, output logic [3:0] a,
                           output logic [3:0] b, output logic [3:0] x, output logic e);
        case (i)
            0:  {op, a, b, x, e} = {3'd0, 4'h3, 4'h4, 4'h7, 1'b0};
            1:  {op, a, b, x, e} = {3'd1, 4'h2, 4'h5, 4'hD, 1'b0};
            2:  {op, a, b, x, e} = {3'd2, 4'h7, 4'h3, 4'h5, 1'b0};
            3:  {op, a, b, x, e} = {3'd3, 4'hF, 4'h4, 4'h3, 1'b0};
            4:  {op, a, b, x, e} = {3'd4, 4'hF, 4'h4, 4'h3, 1'b0};
            5:  {op, a, b, x, e} = {3'd5, 4'hA, 4'h5, 4'hF, 1'b0};
            6:  {op, a, b, x, e} = {3'd6, 4'h5, 4'h0, 4'hA, 1'b0};
            7:  {op, a, b, x, e} = {3'd7, 4'h2, 4'h0, 4'h0, 1'b0};
            8:  {op, a, b, x, e} = {3'd7, 4'h3, 4'h1, 4'h1, 1'b0};
            9:  {op, a, b, x, e} = {3'd0, 4'hF, 4'h1, 4'h0, 1'b0};
            10: {op, a, b, x, e} = {3'd1, 4'h0, 4'h1, 4'hF, 1'b0};
            11: {op, a, b, x, e} = {3'd2, 4'h4, 4'h4, 4'h0, 1'b0};
            12: {op, a, b, x, e} = {3'd3, 4'h8, 4'h0, 4'hF, 1'b1};
            13: {op, a, b, x, e} = {3'd4, 4'h7, 4'h3, 4'h1, 1'b0};
            14: {op, a, b, x, e} = {3'd5, 4'hC, 4'hC, 4'h0, 1'b0};
            15: {op, a, b, x, e} = {3'd6, 4'h0, 4'h0, 4'hF, 1'b0};
            16: {op, a, b, x, e} = {3'd0, 4'h9, 4'h8, 4'h1, 1'b0};
            17: {op, a, b, x, e} = {3'd2, 4'h5, 4'h5, 4'h9, 1'b0};
            18: {op, a, b, x, e} = {3'd3, 4'h7, 4'h7, 4'h1, 1'b0};
            default: {op, a, b, x, e} = {3'd4, 4'h9, 4'h0, 4'hF, 1'b1};
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if ({out_x, out_tag, out_err} !== 9'h000) begin errors++; $display("FAIL reset_out_regs got=%h/%h/%b exp=0/0/0", out_x, out_tag, out_err); end
        checks++; if ({alu_opcode, alu_a, alu_b} !== 11'h000) begin errors++; $display("FAIL reset_alu_idle got=%h/%h/%h exp=0/0/0", alu_opcode, alu_a, alu_b); end
    endtask

    task automatic test_single_add();
        do_reset();
        out_ready = 1'b1;
        set_cmd(1'b1, 3'b000, 4'h3, 4'h4);
        step();
        set_cmd(1'b0, 3'b000, 4'h0, 4'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_no_bypass out_valid got=%b exp=0", out_valid); end
        checks++; if ({alu_opcode, alu_a, alu_b} !== {3'b000, 4'h3, 4'h4}) begin errors++; $display("FAIL add_alu_inputs got=%h/%h/%h exp=0/3/4", alu_opcode, alu_a, alu_b); end
        step();
        $display("add result x=%h tag=%h err=%b", out_x, out_tag, out_err);
        checks++; if ({out_valid, out_x, out_tag, out_err} !== {1'b1, 4'h7, 4'h0, 1'b0}) begin errors++; $display("FAIL add_result got v=%b x=%h t=%h e=%b exp v=1 x=7 t=0 e=0", out_valid, out_x, out_tag, out_err); end
        step();
        checks++; if ({out_valid, busy, out_x} !== {1'b0, 1'b0, 4'h7}) begin errors++; $display("FAIL add_drain got v=%b busy=%b x=%h exp v=0 busy=0 x=7", out_valid, busy, out_x); end
    endtask

    task automatic test_zero_div();
        logic [2:0] ops [3];
        logic [3:0] as [3];
        logic [3:0] bs [3];
        logic [3:0] xs [3];
        logic       es [3];
        ops = '{3'b011, 3'b100, 3'b011};
        as  = '{4'h9, 4'h5, 4'h9};
        bs  = '{4'h0, 4'h0, 4'h2};
        xs  = '{4'hF, 4'hF, 4'h4};
        es  = '{1'b1, 1'b1, 1'b0};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_cmd(1'b1, ops[i], as[i], bs[i]);
            else       set_cmd(1'b0, 3'b000, 4'h0, 4'h0);
            step();
            if (i >= 1) begin
                $display("zdiv result %0d x=%h tag=%h err=%b", i - 1, out_x, out_tag, out_err);
                checks++;
                if ({out_valid, out_x, out_tag, out_err} !== {1'b1, xs[i-1], 4'(i - 1), es[i-1]}) begin
                    errors++;
                    $display("FAIL zdiv_%0d got v=%b x=%h t=%h e=%b exp v=1 x=%h t=%h e=%b",
                             i - 1, out_valid, out_x, out_tag, out_err, xs[i-1], 4'(i - 1), es[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_cmd(1'b1, 3'b000, 4'(k), 4'h1);
            step();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full in_ready got=%b exp=0", in_ready); end
        set_cmd(1'b1, 3'b000, 4'h9, 4'h9);
        step();
        set_cmd(1'b0, 3'b000, 4'h0, 4'h0);
        checks++; if ({in_ready, out_valid, out_x, out_tag} !== {1'b0, 1'b1, 4'h1, 4'h0}) begin errors++; $display("FAIL bp_hold got rdy=%b v=%b x=%h t=%h exp rdy=0 v=1 x=1 t=0", in_ready, out_valid, out_x, out_tag); end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            $display("bp result x=%h tag=%h", out_x, out_tag);
            checks++;
            if ({out_valid, out_x, out_tag} !== {1'b1, 4'(k + 1), 4'(k)}) begin
                errors++;
                $display("FAIL bp_drain_%0d got v=%b x=%h t=%h exp v=1 x=%h t=%h", k, out_valid, out_x, out_tag, 4'(k + 1), 4'(k));
            end
        end
        step();
        checks++; if ({out_valid, busy, out_tag} !== {1'b0, 1'b0, 4'h4}) begin errors++; $display("FAIL bp_empty got v=%b busy=%b t=%h exp v=0 busy=0 t=4", out_valid, busy, out_tag); end
    endtask

    task automatic test_stream();
        logic [2:0] op;
        logic [3:0] a, b, x;
        logic       e;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                get_vec(i, op, a, b, x, e);
                set_cmd(1'b1, op, a, b);
            end else begin
                set_cmd(1'b0, 3'b000, 4'h0, 4'h0);
            end
            step();
            if (i >= 1) begin
                get_vec(i - 1, op, a, b, x, e);
                $display("stream result %0d x=%h tag=%h err=%b", i - 1, out_x, out_tag, out_err);
                checks++;
                if ({out_valid, out_x, out_tag, out_err} !== {1'b1, x, 4'(i - 1), e}) begin
                    errors++;
                    $display("FAIL stream_%0d got v=%b x=%h t=%h e=%b exp v=1 x=%h t=%h e=%b",
                             i - 1, out_valid, out_x, out_tag, out_err, x, 4'(i - 1), e);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_cmd(1'b1, 3'b000, 4'(k), 4'h2);
            step();
        end
        set_cmd(1'b0, 3'b000, 4'h0, 4'h0);
        checks++; if ({out_valid, busy, in_ready} !== 3'b111) begin errors++; $display("FAIL midrst_pre got v=%b busy=%b rdy=%b exp 1/1/1", out_valid, busy, in_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({out_valid, busy, in_ready, out_x, out_tag, alu_a} !== {3'b001, 4'h0, 4'h0, 4'h0}) begin errors++; $display("FAIL midrst_post got v=%b busy=%b rdy=%b x=%h t=%h a=%h exp 0/0/1/0/0/0", out_valid, busy, in_ready, out_x, out_tag, alu_a); end
        out_ready = 1'b1;
        set_cmd(1'b1, 3'b000, 4'h1, 4'h1);
        step();
        set_cmd(1'b0, 3'b000, 4'h0, 4'h0);
        step();
        checks++; if ({out_valid, out_x, out_tag} !== {1'b1, 4'h2, 4'h0}) begin errors++; $display("FAIL midrst_tag got v=%b x=%h t=%h exp v=1 x=2 t=0", out_valid, out_x, out_tag); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_cmd(1'b1, 3'b000, 4'(k), 4'hA);
            step();
        end
        set_cmd(1'b1, 3'b000, 4'h4, 4'hA);
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_pre_ready got=%b exp=1", in_ready); end
        step();
        set_cmd(1'b0, 3'b000, 4'h0, 4'h0);
        checks++; if ({in_ready, out_valid, out_x, out_tag} !== {1'b1, 1'b1, 4'hB, 4'h1}) begin errors++; $display("FAIL b2b_edge got rdy=%b v=%b x=%h t=%h exp rdy=1 v=1 x=b t=1", in_ready, out_valid, out_x, out_tag); end
        for (int k = 2; k < 5; k++) begin
            step();
            checks++;
            if ({out_valid, out_x, out_tag} !== {1'b1, 4'(k + 10), 4'(k)}) begin
                errors++;
                $display("FAIL b2b_order_%0d got v=%b x=%h t=%h exp v=1 x=%h t=%h", k, out_valid, out_x, out_tag, 4'(k + 10), 4'(k));
            end
        end
        step();
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL b2b_empty got v=%b busy=%b exp 0/0", out_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_zero_div();
        test_backpressure();
        test_stream();
        test_reset_midflight();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
